prog_loader: RTL

Program-memory loader that fills the 9-bit × 12-bit instruction store read by the CPU's fetch path (PC → program ROM → IR). It accepts a framed byte stream over a valid/ready handshake, packs byte pairs into 12-bit instruction words, and writes them sequentially into program memory. While loading, it holds the CPU in reset through `cpu_hold`. It releases the CPU only after the whole image has been written and its checksum verified.

---
 rtl/prog_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: receives a framed byte stream, packs byte pairs into
// instruction words, writes them sequentially and releases the CPU only after
// the image checksum matches.
module prog_loader #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_data,
    output logic              pm_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDatLo,
        StDatHi,
        StWrite,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              xfer;

    // byte_ready is decoded from state only, so xfer never feeds back into ready
    assign xfer = byte_valid & byte_ready;

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q  <= StIdle;
            len_lo_q <= '0;
            csum_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            csum_q   <= csum_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic: frame parsing, word packing and checksum accumulation
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        csum_d   = csum_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    csum_d  = '0;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_lo_d = byte_in;
                    csum_d   = csum_q ^ byte_in;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    csum_d = csum_q ^ byte_in;
                    if (byte_in[7:1] != 7'd0) begin
                        state_d = StErr;
                    end else begin
                        // Counter holds remaining words minus one
                        cnt_d   = ADDR_W'({byte_in[0], len_lo_q});
                        addr_d  = ADDR_W'(BASE_ADDR);
                        state_d = StDatLo;
                    end
                end
            end
            StDatLo: begin
                if (xfer) begin
                    data_d[7:0] = byte_in;
                    csum_d      = csum_q ^ byte_in;
                    state_d     = StDatHi;
                end
            end
            StDatHi: begin
                if (xfer) begin
                    // Upper bits of the hi byte are ignored for data but still summed
                    data_d[DATA_W-1:8] = byte_in[DATA_W-9:0];
                    csum_d             = csum_q ^ byte_in;
                    state_d            = StWrite;
                end
            end
            StWrite: begin
                if (cnt_q == '0) begin
                    state_d = StCsum;
                end else begin
                    cnt_d   = cnt_q - ADDR_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StDatLo;
                end
            end
            StCsum: begin
                if (xfer) begin
                    state_d = (byte_in == csum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded purely from state
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        cpu_hold   = 1'b1;
        pm_we      = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StLenLo, StLenHi, StDatLo, StDatHi, StCsum: byte_ready = 1'b1;
            StWrite: pm_we = 1'b1;
            StDone: begin
                busy     = 1'b0;
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            StErr: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    assign pm_addr = addr_q;
    assign pm_data = data_q;

endmodule
